// File: rtl/bus_timer.sv
// Memory-mapped 64-bit machine timer with prescaler, compare interrupt and
// a zero-wait-state word bus port; MTIME_HI reads come from a shadow latched on MTIME_LO reads.
module bus_timer #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    device_req_i,
    input  logic [AddressWidth-1:0] device_addr_i,
    input  logic                    device_we_i,
    input  logic [DataWidth-1:0]    device_wdata_i,
    output logic [DataWidth-1:0]    device_rdata_o,
    output logic                    timer_irq_o
);

    localparam logic [2:0] OffMtimeLo  = 3'd0;
    localparam logic [2:0] OffMtimeHi  = 3'd1;
    localparam logic [2:0] OffCmpLo    = 3'd2;
    localparam logic [2:0] OffCmpHi    = 3'd3;
    localparam logic [2:0] OffCtrl     = 3'd4;
    localparam logic [2:0] OffPrescale = 3'd5;

    logic [63:0] mtime;
    logic [63:0] cmp;
    logic [31:0] pcnt;
    logic [31:0] prescale;
    logic [31:0] shadow;
    logic        enable;

    logic [2:0]  offset;
    logic        write;
    logic        read;
    logic        tick;
    logic [31:0] rdata_next;
    logic        unused_addr;

    assign offset      = device_addr_i[4:2];
    assign unused_addr = ^{device_addr_i[AddressWidth-1:5], device_addr_i[1:0]};
    assign write       = device_req_i && device_we_i;
    assign read        = device_req_i && !device_we_i;
    assign tick        = enable && (pcnt == prescale);

    always_comb begin
        rdata_next = '0;
        case (offset)
            OffMtimeLo:  rdata_next = mtime[31:0];
            OffMtimeHi:  rdata_next = shadow;
            OffCmpLo:    rdata_next = cmp[31:0];
            OffCmpHi:    rdata_next = cmp[63:32];
            OffCtrl:     rdata_next = {31'd0, enable};
            OffPrescale: rdata_next = prescale;
            default:     rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime          <= '0;
            pcnt           <= '0;
            shadow         <= '0;
            cmp            <= '1;
            enable         <= 1'b0;
            prescale       <= '0;
            device_rdata_o <= '0;
            timer_irq_o    <= 1'b0;
        end else begin
            // A bus write to either half replaces the increment entirely, so no carry leaks across.
            if (write && offset == OffMtimeLo) begin
                mtime <= {mtime[63:32], device_wdata_i};
            end else if (write && offset == OffMtimeHi) begin
                mtime <= {device_wdata_i, mtime[31:0]};
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (write && (offset == OffPrescale || offset == OffCtrl)) begin
                pcnt <= '0;
            end else if (enable) begin
                pcnt <= tick ? '0 : pcnt + 32'd1;
            end

            if (write && offset == OffCmpLo) cmp[31:0]  <= device_wdata_i;
            if (write && offset == OffCmpHi) cmp[63:32] <= device_wdata_i;
            if (write && offset == OffCtrl) enable <= device_wdata_i[0];
            if (write && offset == OffPrescale) prescale <= device_wdata_i;

            if (read && offset == OffMtimeLo) shadow <= mtime[63:32];

            device_rdata_o <= read ? rdata_next : '0;
            timer_irq_o    <= enable && (mtime >= cmp);
        end
    end

endmodule
